// File: rtl/ahb_slave_interface_pkg.sv
// Shared AHB-to-APB bridge definitions: transfer/response encodings, peripheral
// address windows and the error-response FSM state codes.
package ahb_slave_interface_pkg;

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransBusy   = 2'b01;
  localparam logic [1:0] HtransNonseq = 2'b10;
  localparam logic [1:0] HtransSeq    = 2'b11;

  localparam logic [1:0] HrespOkay  = 2'b00;
  localparam logic [1:0] HrespError = 2'b01;

  localparam logic [31:0] Slave0Base  = 32'h8000_0000;
  localparam logic [31:0] Slave0Limit = 32'h83FF_FFFF;
  localparam logic [31:0] Slave1Base  = 32'h8400_0000;
  localparam logic [31:0] Slave1Limit = 32'h87FF_FFFF;
  localparam logic [31:0] Slave2Base  = 32'h8800_0000;
  localparam logic [31:0] Slave2Limit = 32'h8BFF_FFFF;

  // Two-cycle ERROR response: first cycle stalls, second completes.
  localparam logic [1:0] ErrOkay   = 2'd0;
  localparam logic [1:0] ErrFirst  = 2'd1;
  localparam logic [1:0] ErrSecond = 2'd2;

endpackage

// File: rtl/ahb_slave_interface.sv
// AHB slave front end of the AHB-to-APB bridge: address decode, two-stage
// address/data pipeline and the two-cycle ERROR response for unmapped transfers.
module ahb_slave_interface
  import ahb_slave_interface_pkg::*;
(
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  input  logic [31:0] Prdata,
  input  logic        Hreadyout_apb,
  output logic [31:0] Haddr1,
  output logic [31:0] Haddr2,
  output logic [31:0] Hwdata1,
  output logic [31:0] Hwdata2,
  output logic        Hwritereg,
  output logic        valid,
  output logic [2:0]  tempselx,
  output logic [31:0] Hrdata,
  output logic [1:0]  Hresp,
  output logic        Hready_o
);

  logic [1:0] err_q, err_d;
  logic       trans_active;

  function automatic logic [2:0] decode_sel(input logic [31:0] addr);
    logic [2:0] sel;
    sel = 3'b000;
    if (addr >= Slave0Base && addr <= Slave0Limit) begin
      sel = 3'b001;
    end else if (addr >= Slave1Base && addr <= Slave1Limit) begin
      sel = 3'b010;
    end else if (addr >= Slave2Base && addr <= Slave2Limit) begin
      sel = 3'b100;
    end
    return sel;
  endfunction

  function automatic logic is_active(input logic [1:0] trans);
    logic act;
    act = 1'b0;
    case (trans)
      HtransNonseq, HtransSeq: act = 1'b1;
      HtransIdle, HtransBusy:  act = 1'b0;
      default:                 act = 1'b0;
    endcase
    return act;
  endfunction

  assign tempselx     = decode_sel(Haddr);
  assign trans_active = Hreadyin && is_active(Htrans);
  assign valid        = trans_active && (tempselx != 3'b000) && (err_q == ErrOkay);
  assign Hrdata       = Prdata;

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      Haddr1    <= '0;
      Haddr2    <= '0;
      Hwdata1   <= '0;
      Hwdata2   <= '0;
      Hwritereg <= 1'b0;
    end else if (Hreadyin) begin
      Haddr1    <= Haddr;
      Haddr2    <= Haddr1;
      Hwdata1   <= Hwdata;
      Hwdata2   <= Hwdata1;
      Hwritereg <= Hwrite;
    end
  end

  // Transfers arriving while an error response is in flight are dropped.
  always_comb begin
    err_d = ErrOkay;
    case (err_q)
      ErrOkay: begin
        if (trans_active && (tempselx == 3'b000)) begin
          err_d = ErrFirst;
        end
      end
      ErrFirst:  err_d = ErrSecond;
      ErrSecond: err_d = ErrOkay;
      default:   err_d = ErrOkay;
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      err_q <= ErrOkay;
    end else begin
      err_q <= err_d;
    end
  end

  // Error states override the APB ready entirely.
  always_comb begin
    Hresp    = HrespOkay;
    Hready_o = Hreadyout_apb;
    case (err_q)
      ErrFirst: begin
        Hresp    = HrespError;
        Hready_o = 1'b0;
      end
      ErrSecond: begin
        Hresp    = HrespError;
        Hready_o = 1'b1;
      end
      default: begin
        Hresp    = HrespOkay;
        Hready_o = Hreadyout_apb;
      end
    endcase
  end

endmodule

// File: tb/tb_ahb_slave_interface.sv
// Self-checking bench for ahb_slave_interface: directed scenarios plus a
// randomized run checked against a behavioural model of the slave.
module tb_ahb_slave_interface;

  logic        Hclk = 1'b0;
  logic        Hresetn = 1'b0;
  logic        Hwrite = 1'b0;
  logic        Hreadyin = 1'b0;
  logic [1:0]  Htrans = 2'b00;
  logic [31:0] Haddr = '0;
  logic [31:0] Hwdata = '0;
  logic [31:0] Prdata = '0;
  logic        Hreadyout_apb = 1'b1;
  logic [31:0] Haddr1, Haddr2, Hwdata1, Hwdata2, Hrdata;
  logic        Hwritereg, valid, Hready_o;
  logic [2:0]  tempselx;
  logic [1:0]  Hresp;

  int vectors = 0;
  int miscompares = 0;

  // Model: pipeline contents and how many error-response cycles have elapsed.
  logic [31:0] m_a1 = '0, m_a2 = '0, m_w1 = '0, m_w2 = '0;
  logic        m_wr = 1'b0;
  int          err_phase = 0;

  ahb_slave_interface dut (
    .Hclk          (Hclk),
    .Hresetn       (Hresetn),
    .Hwrite        (Hwrite),
    .Hreadyin      (Hreadyin),
    .Htrans        (Htrans),
    .Haddr         (Haddr),
    .Hwdata        (Hwdata),
    .Prdata        (Prdata),
    .Hreadyout_apb (Hreadyout_apb),
    .Haddr1        (Haddr1),
    .Haddr2        (Haddr2),
    .Hwdata1       (Hwdata1),
    .Hwdata2       (Hwdata2),
    .Hwritereg     (Hwritereg),
    .valid         (valid),
    .tempselx      (tempselx),
    .Hrdata        (Hrdata),
    .Hresp         (Hresp),
    .Hready_o      (Hready_o)
  );

  always #5 Hclk = ~Hclk;

  // Each 64 MB window from 0x8000_0000 selects the next peripheral, three in all.
  function automatic logic [2:0] ref_sel(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a < 32'h8C00_0000) return 3'b001 << ((a - 32'h8000_0000) >> 26);
    return 3'b000;
  endfunction

  function automatic logic ref_valid();
    return Hreadyin && (Htrans >= 2) && (ref_sel(Haddr) != 0) && (err_phase == 0);
  endfunction

  task automatic model_reset();
    m_a1 = '0; m_a2 = '0; m_w1 = '0; m_w2 = '0; m_wr = 1'b0; err_phase = 0;
  endtask

  // Advance one clock, updating the model from the inputs seen before the edge.
  task automatic step();
    int n_phase;
    if (err_phase == 1) n_phase = 2;
    else if (err_phase == 2) n_phase = 0;
    else n_phase = (Hreadyin && Htrans >= 2 && ref_sel(Haddr) == 0) ? 1 : 0;
    @(posedge Hclk);
    if (Hreadyin) begin
      m_a2 = m_a1; m_a1 = Haddr; m_w2 = m_w1; m_w1 = Hwdata; m_wr = Hwrite;
    end
    err_phase = n_phase;
    #1;
  endtask

  task automatic test_reset();
    Hreadyin = 1'b1; Htrans = 2'b10; Haddr = 32'h8400_0100; Hwdata = $urandom;
    Prdata = 32'hCAFE_F00D; Hwrite = 1'b1; Hreadyout_apb = 1'b1;
    repeat (2) @(posedge Hclk);
    #1;
    vectors++;
    if ({Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg} !== '0) begin
      miscompares++;
      $display("FAIL reset_regs got %h %h %h %h %b want all 0", Haddr1, Haddr2, Hwdata1,
               Hwdata2, Hwritereg);
    end
    vectors++;
    if (Hresp !== 2'b00 || Hready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_resp got %b/%b want 00/1", Hresp, Hready_o);
    end
    vectors++;
    if (tempselx !== 3'b010 || valid !== 1'b1 || Hrdata !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("FAIL reset_comb got sel=%b valid=%b rdata=%h want 010/1/cafef00d", tempselx,
               valid, Hrdata);
    end
    @(negedge Hclk);
    Hresetn = 1'b1;
    Htrans = 2'b00;
    model_reset();
    step();
  endtask

  task automatic test_single_write();
    Hreadyin = 1'b1; Htrans = 2'b10; Hwrite = 1'b1; Haddr = 32'h8000_0010;
    Hwdata = 32'hA5A5_A5A5; Hreadyout_apb = 1'b1;
    #1;
    vectors++;
    if (valid !== 1'b1 || tempselx !== 3'b001) begin
      miscompares++;
      $display("FAIL write_decode got valid=%b sel=%b want 1/001", valid, tempselx);
    end
    step();
    Htrans = 2'b00; Hwrite = 1'b0; Haddr = 32'h0; Hwdata = 32'h0;
    vectors++;
    if (Haddr1 !== 32'h8000_0010 || Hwritereg !== 1'b1 || Hwdata1 !== 32'hA5A5_A5A5) begin
      miscompares++;
      $display("FAIL write_stage1 got a1=%h wr=%b w1=%h want 80000010/1/a5a5a5a5", Haddr1,
               Hwritereg, Hwdata1);
    end
    step();
    vectors++;
    if (Haddr2 !== 32'h8000_0010 || Hwdata2 !== 32'hA5A5_A5A5) begin
      miscompares++;
      $display("FAIL write_stage2 got a2=%h w2=%h want 80000010/a5a5a5a5", Haddr2, Hwdata2);
    end
  endtask

  task automatic test_read_burst();
    Hreadyin = 1'b1; Hwrite = 1'b0; Prdata = 32'h1234_5678;
    Htrans = 2'b10; Haddr = 32'h8400_0000;
    #1;
    vectors++;
    if (tempselx !== 3'b010 || valid !== 1'b1 || Hrdata !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL burst_nonseq got sel=%b valid=%b rdata=%h want 010/1/12345678", tempselx,
               valid, Hrdata);
    end
    step();
    Htrans = 2'b11; Haddr = 32'h8400_0004;
    #1;
    vectors++;
    if (tempselx !== 3'b010 || valid !== 1'b1 || Haddr1 !== 32'h8400_0000) begin
      miscompares++;
      $display("FAIL burst_seq got sel=%b valid=%b a1=%h want 010/1/84000000", tempselx, valid,
               Haddr1);
    end
    step();
    Htrans = 2'b00;
    vectors++;
    if (Haddr1 !== 32'h8400_0004 || Haddr2 !== 32'h8400_0000 || Hwritereg !== 1'b0) begin
      miscompares++;
      $display("FAIL burst_shift got a1=%h a2=%h wr=%b want 84000004/84000000/0", Haddr1,
               Haddr2, Hwritereg);
    end
    Prdata = 32'h0BAD_BEEF;
    #1;
    vectors++;
    if (Hrdata !== 32'h0BAD_BEEF) begin
      miscompares++;
      $display("FAIL burst_rdata got %h want 0badbeef", Hrdata);
    end
  endtask

  task automatic test_error();
    Hreadyin = 1'b1; Htrans = 2'b10; Haddr = 32'h9000_0000; Hreadyout_apb = 1'b0;
    #1;
    vectors++;
    if (valid !== 1'b0 || tempselx !== 3'b000 || Hresp !== 2'b00) begin
      miscompares++;
      $display("FAIL err_present got valid=%b sel=%b resp=%b want 0/000/00", valid, tempselx,
               Hresp);
    end
    step();
    // Another unmapped NONSEQ during the response must not restart it.
    #1;
    vectors++;
    if (Hresp !== 2'b01 || Hready_o !== 1'b0 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL err_first got resp=%b rdy=%b valid=%b want 01/0/0", Hresp, Hready_o, valid);
    end
    step();
    Haddr = 32'h8000_0000;
    #1;
    vectors++;
    if (Hresp !== 2'b01 || Hready_o !== 1'b1 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL err_second got resp=%b rdy=%b valid=%b want 01/1/0", Hresp, Hready_o,
               valid);
    end
    step();
    Htrans = 2'b00; Hreadyout_apb = 1'b1;
    #1;
    vectors++;
    if (Hresp !== 2'b00 || Hready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL err_done got resp=%b rdy=%b want 00/1", Hresp, Hready_o);
    end
    step();
  endtask

  task automatic test_stall();
    logic [31:0] a1, a2, w1, w2;
    logic        wr;
    Hreadyin = 1'b1; Htrans = 2'b10; Haddr = 32'h8800_0040; Hwdata = 32'h1111_2222;
    Hwrite = 1'b1;
    step();
    Haddr = 32'h8000_0044; Hwdata = 32'h3333_4444; Hwrite = 1'b0;
    step();
    a1 = m_a1; a2 = m_a2; w1 = m_w1; w2 = m_w2; wr = m_wr;
    Hreadyin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      Haddr = $urandom; Hwdata = $urandom; Hwrite = ~Hwrite;
      step();
      vectors++;
      if ({Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg} !== {a1, a2, w1, w2, wr}) begin
        miscompares++;
        $display("FAIL stall_hold%0d got %h %h %h %h %b want %h %h %h %h %b", i, Haddr1, Haddr2,
                 Hwdata1, Hwdata2, Hwritereg, a1, a2, w1, w2, wr);
      end
    end
    vectors++;
    if (Hresp !== 2'b00) begin
      miscompares++;
      $display("FAIL stall_resp got %b want 00", Hresp);
    end
    Hreadyin = 1'b1; Htrans = 2'b00;
  endtask

  task automatic test_busy();
    Hreadyin = 1'b1; Htrans = 2'b01; Haddr = 32'h8800_0000; Hreadyout_apb = 1'b1;
    #1;
    vectors++;
    if (valid !== 1'b0 || tempselx !== 3'b100 || Hresp !== 2'b00) begin
      miscompares++;
      $display("FAIL busy_comb got valid=%b sel=%b resp=%b want 0/100/00", valid, tempselx,
               Hresp);
    end
    Haddr = 32'hF000_0000;
    step();
    Htrans = 2'b00;
    step();
    vectors++;
    if (Hresp !== 2'b00 || Hready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_no_err got resp=%b rdy=%b want 00/1", Hresp, Hready_o);
    end
  endtask

  task automatic test_async_reset();
    Hreadyin = 1'b1; Htrans = 2'b10; Haddr = 32'hA000_0000; Hwdata = 32'h5A5A_0001;
    Hwrite = 1'b1; Hreadyout_apb = 1'b1;
    step();
    Htrans = 2'b00;
    vectors++;
    if (Hresp !== 2'b01 || Hready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL arst_enter got resp=%b rdy=%b want 01/0", Hresp, Hready_o);
    end
    #2;
    Hresetn = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (Hresp !== 2'b00 || Hready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL arst_resp got resp=%b rdy=%b want 00/1", Hresp, Hready_o);
    end
    vectors++;
    if ({Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg} !== '0) begin
      miscompares++;
      $display("FAIL arst_regs got %h %h %h %h %b want all 0", Haddr1, Haddr2, Hwdata1,
               Hwdata2, Hwritereg);
    end
    @(negedge Hclk);
    Hresetn = 1'b1;
    step();
    vectors++;
    if (Hresp !== 2'b00 || Hready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL arst_release got resp=%b rdy=%b want 00/1", Hresp, Hready_o);
    end
    Htrans = 2'b10; Haddr = 32'h8000_0000;
    #1;
    vectors++;
    if (valid !== 1'b1) begin
      miscompares++;
      $display("FAIL arst_okay got valid=%b want 1", valid);
    end
    step();
  endtask

  task automatic test_random();
    logic [31:0] edges [5];
    logic [2:0]  e_sel;
    logic        e_valid, e_rdy;
    logic [1:0]  e_resp;
    edges[0] = 32'h83FF_FFFF; edges[1] = 32'h8400_0000; edges[2] = 32'h8BFF_FFFF;
    edges[3] = 32'h8C00_0000; edges[4] = 32'h7FFF_FFFF;
    for (int i = 0; i < 300; i++) begin
      Hreadyin = ($urandom_range(0, 3) != 0);
      Htrans = 2'($urandom_range(0, 3));
      Hwrite = 1'($urandom);
      Hwdata = $urandom;
      Prdata = $urandom;
      Hreadyout_apb = 1'($urandom);
      case ($urandom_range(0, 5))
        0, 1, 2: Haddr = 32'h8000_0000 + ($urandom_range(0, 2) << 26) + ($urandom & 32'h03FF_FFFC);
        3: Haddr = $urandom & 32'h7FFF_FFFF;
        4: Haddr = 32'h9000_0000 | ($urandom & 32'h0FFF_FFFF);
        default: Haddr = edges[$urandom_range(0, 4)];
      endcase
      #1;
      e_sel = ref_sel(Haddr);
      e_valid = ref_valid();
      e_resp = (err_phase == 0) ? 2'b00 : 2'b01;
      e_rdy = (err_phase == 0) ? Hreadyout_apb : (err_phase == 2);
      vectors++;
      if (tempselx !== e_sel || valid !== e_valid || Hrdata !== Prdata) begin
        miscompares++;
        $display("FAIL rnd_comb%0d addr=%h got sel=%b valid=%b rdata=%h want %b/%b/%h", i, Haddr,
                 tempselx, valid, Hrdata, e_sel, e_valid, Prdata);
      end
      vectors++;
      if (Hresp !== e_resp || Hready_o !== e_rdy) begin
        miscompares++;
        $display("FAIL rnd_resp%0d got %b/%b want %b/%b", i, Hresp, Hready_o, e_resp, e_rdy);
      end
      step();
      vectors++;
      if ({Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg} !== {m_a1, m_a2, m_w1, m_w2, m_wr}) begin
        miscompares++;
        $display("FAIL rnd_pipe%0d got %h %h %h %h %b want %h %h %h %h %b", i, Haddr1, Haddr2,
                 Hwdata1, Hwdata2, Hwritereg, m_a1, m_a2, m_w1, m_w2, m_wr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_burst();
    test_error();
    test_stall();
    test_busy();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
